conv_layer_sequencer: RTL and testbench
=======================================

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, width of every configuration and status word.
REQ-002 SHALL have parameter NUM_LAYER_MAX, default 8, depth of the layer descriptor table.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles between loading the config outputs and asserting start.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, per-layer watchdog limit (used only under REQ-027).
REQ-005 SHALL have ports, in order:
  clk  in  1  single clock, all logic on rising edge;
  rst  in  1  reset, synchronous, active-high;
  i_tbl_wren  in  1  host table write strobe;
  i_tbl_addr  in  $clog2(NUM_LAYER_MAX)+3  {layer index, field[2:0]};
  i_tbl_wdat  in  REG_WIDTH  table write data;
  i_seq_start  in  1  one-cycle start request;
  i_seq_num_layer  in  $clog2(NUM_LAYER_MAX)+1  layers to run;
  i_seq_abort  in  1  abort request;
  i_core_status  in  REG_WIDTH  core o_conf_status, bit0 = layer done (level, held until ctrl bit0 drops);
  o_conf_ctrl, o_conf_outputsize, o_conf_kernelsize, o_conf_weightinterval, o_conf_kernelshape, o_conf_inputshape, o_conf_inputrstcnt  out  REG_WIDTH each  core configuration words;
  o_seq_busy  out  1  high in every state except IDLE;
  o_seq_layer  out  $clog2(NUM_LAYER_MAX)  current layer index;
  o_seq_done  out  1  one-cycle pulse, all layers complete;
  o_seq_err  out  1  one-cycle pulse, rejected start or timeout.

Function
REQ-006 Table SHALL hold NUM_LAYER_MAX descriptors of six REG_WIDTH fields: 0 outputsize, 1 kernelsize, 2 weightinterval, 3 kernelshape, 4 inputshape, 5 inputrstcnt.
REQ-007 Table writes SHALL take effect on the next clock edge only in IDLE; field codes 6/7 and writes outside IDLE SHALL be ignored.
REQ-008 FSM states SHALL be IDLE, LOAD, SETTLE, START, RUN, CLEAR, DONE.
REQ-009 IDLE -> LOAD on i_seq_start when 1 <= i_seq_num_layer <= NUM_LAYER_MAX; num_layer is latched and layer index cleared to 0.
REQ-010 i_seq_start with num_layer 0 or > NUM_LAYER_MAX SHALL stay in IDLE and pulse o_seq_err for one cycle.
REQ-011 LOAD (1 cycle) SHALL register the six o_conf_* words from table[layer]; -> SETTLE.
REQ-012 SETTLE SHALL last exactly SETTLE_CYCLES cycles (0 = skip); -> START.
REQ-013 START (1 cycle) SHALL set o_conf_ctrl to 32'h1; -> RUN.
REQ-014 RUN SHALL hold o_conf_ctrl = 32'h1 until i_core_status[0] = 1; -> CLEAR.
REQ-015 CLEAR SHALL drive o_conf_ctrl = 0 and wait for i_core_status[0] = 0; then -> DONE if layer = num_layer-1, else layer+1 and -> LOAD.
REQ-016 DONE (1 cycle) SHALL pulse o_seq_done; -> IDLE; o_conf_* retain last values.
REQ-017 i_seq_start outside IDLE SHALL be ignored without error.
REQ-018 i_seq_abort in any non-IDLE state SHALL force o_conf_ctrl = 0 and IDLE on the next edge, with no o_seq_done; abort has priority over every other transition.
REQ-019 o_conf_ctrl bits [REG_WIDTH-1:1] SHALL always be 0.
REQ-020 All outputs SHALL be registered; latency start -> o_conf_ctrl=1 is 3+SETTLE_CYCLES cycles.

Reset
REQ-021 On rst high at a clock edge, FSM SHALL go to IDLE and all outputs SHALL be 0, overriding any in-flight layer.
REQ-022 Table contents SHALL be reset to 0.
REQ-023 A rst mid-RUN SHALL drop o_conf_ctrl to 0 on that edge.

Configuration
REQ-024 Macro SEQ_TIMEOUT_EN SHALL compile in a per-layer watchdog counter cleared in START.
REQ-025 With SEQ_TIMEOUT_EN, RUN or CLEAR exceeding TIMEOUT_CYCLES SHALL drive o_conf_ctrl = 0, pulse o_seq_err, and go to IDLE.
REQ-026 Without SEQ_TIMEOUT_EN, no counter SHALL exist and RUN/CLEAR wait indefinitely.
REQ-027 TIMEOUT_CYCLES SHALL be unused when the macro is absent.

Structure
REQ-028 State encoding, field-index constants (FLD_OUTPUTSIZE..FLD_INPUTRSTCNT) and REG_WIDTH SHALL live in shared package dnn_accel_pkg.
REQ-029 Descriptor storage SHALL be one sub-module, layer_desc_regfile (write port plus 6-wide combinational read by layer index).

Verification
REQ-030 Write layer0 {12320, 0x00020009, 36962, 0x00080333, 0x000103e0, 24863}, start num=1 -> o_conf_* match after LOAD, ctrl=1 at cycle 5, status[0]=1 -> ctrl=0, status[0]=0 -> o_seq_done pulse.
REQ-031 Three layers, num=3 -> o_seq_layer 0,1,2, three ctrl pulses, one done pulse.
REQ-032 Start with num=0 and num=9 -> o_seq_err pulses, busy stays 0.
REQ-033 Abort in RUN -> next cycle ctrl=0, busy=0, no done; table write during RUN -> table unchanged.
REQ-034 With SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, status never set -> err pulse 100 cycles after START, ctrl=0.
REQ-035 rst asserted in RUN -> all outputs 0 next edge, table reads back 0.

Source files
------------

// File: rtl/dnn_accel_pkg.sv
// Shared control-path constants for the DNN accelerator: register width,
// descriptor field indices and the layer-sequencer state encoding.
package dnn_accel_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int NUM_FIELDS = 6;

  localparam logic [2:0] FLD_OUTPUTSIZE     = 3'd0;
  localparam logic [2:0] FLD_KERNELSIZE     = 3'd1;
  localparam logic [2:0] FLD_WEIGHTINTERVAL = 3'd2;
  localparam logic [2:0] FLD_KERNELSHAPE    = 3'd3;
  localparam logic [2:0] FLD_INPUTSHAPE     = 3'd4;
  localparam logic [2:0] FLD_INPUTRSTCNT    = 3'd5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_CLEAR  = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // Field codes 6 and 7 have no storage behind them.
  function automatic logic field_valid(input logic [2:0] fld);
    return fld <= FLD_INPUTRSTCNT;
  endfunction

endpackage

// File: rtl/layer_desc_regfile.sv
// Layer descriptor table: one host write port, and a combinational read of
// all six fields of the selected layer.
module layer_desc_regfile
  import dnn_accel_pkg::*;
#(
  parameter int REG_WIDTH     = dnn_accel_pkg::REG_WIDTH,
  parameter int NUM_LAYER_MAX = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_wren,
  input  logic [$clog2(NUM_LAYER_MAX)-1:0]            i_wr_layer,
  input  logic [2:0]                                  i_wr_field,
  input  logic [REG_WIDTH-1:0]                        i_wdat,
  input  logic [$clog2(NUM_LAYER_MAX)-1:0]            i_rd_layer,
  output logic [NUM_FIELDS-1:0][REG_WIDTH-1:0]        o_rd_desc
);

  logic [REG_WIDTH-1:0] mem_q [NUM_LAYER_MAX][NUM_FIELDS];
  logic [REG_WIDTH-1:0] mem_d [NUM_LAYER_MAX][NUM_FIELDS];

  always_comb begin
    // NOTE: start from the held value so every path assigns mem_d and no latch is inferred.
    mem_d = mem_q;
    if (i_wren && field_valid(i_wr_field) && (int'(i_wr_layer) < NUM_LAYER_MAX)) begin
      mem_d[i_wr_layer][i_wr_field] = i_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is small flop storage, so it is cleared on reset; a RAM macro could not be.
      for (int l = 0; l < NUM_LAYER_MAX; l++) begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
          mem_q[l][f] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      mem_q <= mem_d;
    end
  end

  always_comb begin
    o_rd_desc = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      o_rd_desc[f] = mem_q[i_rd_layer][f];
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Walks the descriptor table layer by layer, programming and kicking the conv core.
// Optional per-layer watchdog compiled in with `define SEQ_TIMEOUT_EN.
module conv_layer_sequencer
  import dnn_accel_pkg::*;
#(
  parameter int          REG_WIDTH      = dnn_accel_pkg::REG_WIDTH,
  parameter int          NUM_LAYER_MAX  = 8,
  parameter int          SETTLE_CYCLES  = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_tbl_wren,
  input  logic [$clog2(NUM_LAYER_MAX)+2:0]   i_tbl_addr,
  input  logic [REG_WIDTH-1:0]               i_tbl_wdat,
  input  logic                               i_seq_start,
  input  logic [$clog2(NUM_LAYER_MAX):0]     i_seq_num_layer,
  input  logic                               i_seq_abort,
  input  logic [REG_WIDTH-1:0]               i_core_status,
  output logic [REG_WIDTH-1:0]               o_conf_ctrl,
  output logic [REG_WIDTH-1:0]               o_conf_outputsize,
  output logic [REG_WIDTH-1:0]               o_conf_kernelsize,
  output logic [REG_WIDTH-1:0]               o_conf_weightinterval,
  output logic [REG_WIDTH-1:0]               o_conf_kernelshape,
  output logic [REG_WIDTH-1:0]               o_conf_inputshape,
  output logic [REG_WIDTH-1:0]               o_conf_inputrstcnt,
  output logic                               o_seq_busy,
  output logic [$clog2(NUM_LAYER_MAX)-1:0]   o_seq_layer,
  output logic                               o_seq_done,
  output logic                               o_seq_err
);

  localparam int LW = $clog2(NUM_LAYER_MAX);
  localparam int NW = LW + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [2:0]                           state_q, state_d;
  logic [LW-1:0]                        layer_q, layer_d;
  logic [NW-1:0]                        num_q, num_d;
  logic [SW-1:0]                        settle_q, settle_d;
  logic [NUM_FIELDS-1:0][REG_WIDTH-1:0] conf_q, conf_d, rd_desc;
  logic ctrl_q, ctrl_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic start_ok, last_layer, timeout;

  // Only the done bit of the core status word carries meaning here.
  logic unused_status;
  assign unused_status = ^i_core_status[REG_WIDTH-1:1];

  layer_desc_regfile #(
    .REG_WIDTH     (REG_WIDTH),
    .NUM_LAYER_MAX (NUM_LAYER_MAX)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_wren     (i_tbl_wren && (state_q == ST_IDLE)),
    .i_wr_layer (i_tbl_addr[LW+2:3]),
    .i_wr_field (i_tbl_addr[2:0]),
    .i_wdat     (i_tbl_wdat),
    .i_rd_layer (layer_q),
    .o_rd_desc  (rd_desc)
  );

  assign start_ok   = (i_seq_num_layer != '0) && (int'(i_seq_num_layer) <= NUM_LAYER_MAX);
  assign last_layer = (({1'b0, layer_q} + 1'b1) == num_q);

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_START) begin
      wdog_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_CLEAR)) begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  // wdog_q counts completed RUN/CLEAR cycles; trip when this one would exceed the limit.
  assign timeout = ((state_q == ST_RUN) || (state_q == ST_CLEAR)) &&
                   (wdog_q >= (TIMEOUT_CYCLES - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    num_d    = num_q;
    settle_d = settle_q;
    conf_d   = conf_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_seq_start) begin
          if (start_ok) begin
            state_d = ST_LOAD;
            num_d   = i_seq_num_layer;
            layer_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        conf_d   = rd_desc;
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? ST_START : ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) state_d = ST_START;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (i_core_status[0]) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!i_core_status[0]) begin
          if (last_layer) begin
            state_d = ST_DONE;
          end else begin
            layer_d = layer_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
    // Abort wins over everything, including a watchdog trip in the same cycle.
    if (i_seq_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
    end
  end

  // Status outputs are decoded from the next state so they line up with it.
  assign ctrl_d = (state_d == ST_RUN);
  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      layer_q  <= '0;
      num_q    <= '0;
      settle_q <= '0;
      conf_q   <= '0;
      ctrl_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      num_q    <= num_d;
      settle_q <= settle_d;
      conf_q   <= conf_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_conf_ctrl           = {{(REG_WIDTH-1){1'b0}}, ctrl_q};
  assign o_conf_outputsize     = conf_q[FLD_OUTPUTSIZE];
  assign o_conf_kernelsize     = conf_q[FLD_KERNELSIZE];
  assign o_conf_weightinterval = conf_q[FLD_WEIGHTINTERVAL];
  assign o_conf_kernelshape    = conf_q[FLD_KERNELSHAPE];
  assign o_conf_inputshape     = conf_q[FLD_INPUTSHAPE];
  assign o_conf_inputrstcnt    = conf_q[FLD_INPUTRSTCNT];
  assign o_seq_busy            = busy_q;
  assign o_seq_layer           = layer_q;
  assign o_seq_done            = done_q;
  assign o_seq_err             = err_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer: the driver pushes expected
// ctrl-rise / done / err events, a negedge monitor pops and compares them.
module tb_conv_layer_sequencer;

  localparam int RW  = 32;
  localparam int NL  = 8;
  localparam int SC  = 2;
  localparam int TO  = 100;
  localparam int LW  = $clog2(NL);
  localparam int NW  = LW + 1;
  // Edges from the edge that samples start (or the status drop) to ctrl=1:
  // one LOAD, SC settle cycles, one START. Counting the start cycle as 0 this is cycle 3+SC.
  localparam int LAT = 2 + SC;

  typedef enum int {EV_CTRL = 1, EV_DONE = 2, EV_ERR = 3} ev_kind_e;
  typedef struct {
    ev_kind_e              kind;
    int                    cycle;
    int                    layer;
    logic [5:0][RW-1:0]    conf;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_tbl_wren;
  logic [LW+2:0] i_tbl_addr;
  logic [RW-1:0] i_tbl_wdat;
  logic          i_seq_start;
  logic [NW-1:0] i_seq_num_layer;
  logic          i_seq_abort;
  logic [RW-1:0] i_core_status;
  logic [RW-1:0] o_conf_ctrl, o_conf_outputsize, o_conf_kernelsize, o_conf_weightinterval;
  logic [RW-1:0] o_conf_kernelshape, o_conf_inputshape, o_conf_inputrstcnt;
  logic          o_seq_busy, o_seq_done, o_seq_err;
  logic [LW-1:0] o_seq_layer;

  conv_layer_sequencer #(
    .REG_WIDTH      (RW),
    .NUM_LAYER_MAX  (NL),
    .SETTLE_CYCLES  (SC),
    .TIMEOUT_CYCLES (32'(TO))
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_tbl_wren            (i_tbl_wren),
    .i_tbl_addr            (i_tbl_addr),
    .i_tbl_wdat            (i_tbl_wdat),
    .i_seq_start           (i_seq_start),
    .i_seq_num_layer       (i_seq_num_layer),
    .i_seq_abort           (i_seq_abort),
    .i_core_status         (i_core_status),
    .o_conf_ctrl           (o_conf_ctrl),
    .o_conf_outputsize     (o_conf_outputsize),
    .o_conf_kernelsize     (o_conf_kernelsize),
    .o_conf_weightinterval (o_conf_weightinterval),
    .o_conf_kernelshape    (o_conf_kernelshape),
    .o_conf_inputshape     (o_conf_inputshape),
    .o_conf_inputrstcnt    (o_conf_inputrstcnt),
    .o_seq_busy            (o_seq_busy),
    .o_seq_layer           (o_seq_layer),
    .o_seq_done            (o_seq_done),
    .o_seq_err             (o_seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [5:0][RW-1:0] dut_conf;
  assign dut_conf = {o_conf_inputrstcnt, o_conf_inputshape, o_conf_kernelshape,
                     o_conf_weightinterval, o_conf_kernelsize, o_conf_outputsize};

  // Reference model: the table as the host believes it, and whether a run is in flight.
  logic [RW-1:0] tbl [NL][6];
  bit            seq_active = 1'b0;
  ev_t           exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input ev_kind_e kind, input int cycle, input int layer);
    ev_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.layer = layer;
    for (int f = 0; f < 6; f++) e.conf[f] = (kind == EV_CTRL) ? tbl[layer][f] : '0;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation for every event the DUT presents.
  task automatic observe(input ev_kind_e kind);
    ev_t e;
    check("event_pending", RW'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cycle);
      if (kind == EV_CTRL) begin
        check("seq_layer", RW'(o_seq_layer), e.layer);
        check("ctrl_upper_bits", o_conf_ctrl >> 1, 0);
        for (int f = 0; f < 6; f++) check($sformatf("conf_field%0d", f), dut_conf[f], e.conf[f]);
      end
    end
  endtask

  logic prev_ctrl = 1'b0;
  always @(negedge clk) begin
    if (o_conf_ctrl[0] === 1'b1 && !prev_ctrl) observe(EV_CTRL);
    if (o_seq_done === 1'b1) observe(EV_DONE);
    if (o_seq_err === 1'b1) observe(EV_ERR);
    prev_ctrl = (o_conf_ctrl[0] === 1'b1);
  end

  task automatic tbl_write(input int layer, input int field, input logic [RW-1:0] data);
    i_tbl_wren = 1'b1;
    i_tbl_addr = {LW'(layer), 3'(field)};
    i_tbl_wdat = data;
    if (!seq_active && field < 6) tbl[layer][field] = data;
    step();
    i_tbl_wren = 1'b0;
  endtask

  task automatic start_seq(input int num);
    i_seq_start     = 1'b1;
    i_seq_num_layer = NW'(num);
    if (num >= 1 && num <= NL) begin
      push_ev(EV_CTRL, cyc + 1 + LAT, 0);
      seq_active = 1'b1;
    end else begin
      push_ev(EV_ERR, cyc + 1, 0);
    end
    step();
    i_seq_start = 1'b0;
  endtask

  task automatic wait_ctrl(input logic val, input string name);
    int n = 0;
    while (o_conf_ctrl[0] !== val && n < 300) begin
      step();
      n++;
    end
    check(name, RW'(o_conf_ctrl[0]), RW'(val));
  endtask

  // Behaves as the core: raise done some time after ctrl, drop it after ctrl clears.
  task automatic run_layers(input int num, input bit poke_start);
    logic [RW-1:0] r;
    for (int k = 0; k < num; k++) begin
      wait_ctrl(1'b1, "ctrl_rise");
      if (poke_start && k == 0) begin
        i_seq_start = 1'b1;
        i_seq_num_layer = NW'(1);
        step();
        i_seq_start = 1'b0;
      end
      repeat ($urandom_range(0, 4)) step();
      r = $urandom;
      i_core_status = r | 32'h1;
      wait_ctrl(1'b0, "ctrl_fall");
      repeat ($urandom_range(0, 3)) step();
      r = $urandom;
      i_core_status = r & ~32'h1;
      if (k == num - 1) push_ev(EV_DONE, cyc + 1, k);
      else              push_ev(EV_CTRL, cyc + 1 + LAT, k + 1);
      step();
    end
    step();
    seq_active = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, o_conf_ctrl, 0);
    for (int f = 0; f < 6; f++) check($sformatf("%s_conf%0d", tag, f), dut_conf[f], 0);
    check({tag, "_busy"}, RW'(o_seq_busy), 0);
    check({tag, "_layer"}, RW'(o_seq_layer), 0);
    check({tag, "_done"}, RW'(o_seq_done), 0);
    check({tag, "_err"}, RW'(o_seq_err), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    logic [RW-1:0] r;
    int num;
    rst = 1'b1; i_tbl_wren = 1'b0; i_tbl_addr = '0; i_tbl_wdat = '0;
    i_seq_start = 1'b0; i_seq_num_layer = '0; i_seq_abort = 1'b0; i_core_status = '0;
    for (int l = 0; l < NL; l++) for (int f = 0; f < 6; f++) tbl[l][f] = '0;
    repeat (3) step();
    rst = 1'b0;
    check_all_zero("reset");

    // Directed single layer with known descriptor values.
    tbl_write(0, 0, 32'd12320);
    tbl_write(0, 1, 32'h0002_0009);
    tbl_write(0, 2, 32'd36962);
    tbl_write(0, 3, 32'h0008_0333);
    tbl_write(0, 4, 32'h0001_03e0);
    tbl_write(0, 5, 32'd24863);
    start_seq(1);
    run_layers(1, 1'b0);

    // Three layers, with a start request poked in while running.
    for (int l = 0; l < 3; l++) for (int f = 0; f < 6; f++) tbl_write(l, f, $urandom);
    start_seq(3);
    run_layers(3, 1'b1);

    // Rejected starts.
    start_seq(0);
    check("err0_busy", RW'(o_seq_busy), 0);
    start_seq(NL + 1);
    check("err9_busy", RW'(o_seq_busy), 0);
    start_seq($urandom_range(NL + 1, (1 << NW) - 1));
    check("err_rand_busy", RW'(o_seq_busy), 0);
    step();

    // Random tables (including writes to unused field codes) and layer counts.
    for (int it = 0; it < 3; it++) begin
      for (int l = 0; l < NL; l++) for (int f = 0; f < 8; f++) tbl_write(l, f, $urandom);
      num = $urandom_range(1, NL);
      start_seq(num);
      run_layers(num, 1'b0);
    end

    // Abort in RUN after a table write that must be ignored.
    start_seq(1);
    wait_ctrl(1'b1, "abort_ctrl_rise");
    r = $urandom;
    tbl_write(0, 0, r);
    i_seq_abort = 1'b1;
    step();
    i_seq_abort = 1'b0;
    check("abort_ctrl", o_conf_ctrl, 0);
    check("abort_busy", RW'(o_seq_busy), 0);
    check("abort_done", RW'(o_seq_done), 0);
    seq_active = 1'b0;
    step();
    start_seq(1);
    run_layers(1, 1'b0);

`ifdef SEQ_TIMEOUT_EN
    // Core never reports done: watchdog fires TO cycles after ctrl rises.
    start_seq(1);
    wait_ctrl(1'b1, "wdog_ctrl_rise");
    push_ev(EV_ERR, cyc + TO, 0);
    repeat (TO + 3) step();
    check("wdog_ctrl", o_conf_ctrl, 0);
    check("wdog_busy", RW'(o_seq_busy), 0);
    seq_active = 1'b0;
`else
    // Without a watchdog the sequencer keeps waiting on the core.
    start_seq(1);
    wait_ctrl(1'b1, "hold_ctrl_rise");
    repeat (150) step();
    check("hold_ctrl", o_conf_ctrl, 1);
    check("hold_busy", RW'(o_seq_busy), 1);
    i_seq_abort = 1'b1;
    step();
    i_seq_abort = 1'b0;
    seq_active = 1'b0;
`endif
    step();

    // Reset in the middle of RUN clears outputs and the table.
    start_seq(2);
    wait_ctrl(1'b1, "rst_ctrl_rise");
    rst = 1'b1;
    step();
    check_all_zero("midrun_reset");
    rst = 1'b0;
    for (int l = 0; l < NL; l++) for (int f = 0; f < 6; f++) tbl[l][f] = '0;
    seq_active = 1'b0;
    step();
    start_seq(1);
    run_layers(1, 1'b0);

    repeat (5) step();
    check("queue_drained", RW'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
